// File: rtl/led_counter.sv
// LED up/down counter stepped by rising edges of a slow data-sampled clock, with run/hold FSM and load.
// Define LED_COUNTER_SYNC_EN to pass slow_clk through a 2-flop synchronizer before edge detection.
module led_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick_o,
    output logic             wrap_o,
    output logic [1:0]       state_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;

    logic             s_last;
    logic             s_prev;
    logic             slow_rise;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             step;
    logic             at_limit;
    logic [WIDTH-1:0] count_step;
    logic [WIDTH-1:0] load_clamped;

`ifdef LED_COUNTER_SYNC_EN
    logic s_meta;

    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s_last <= 1'b0;
        end else begin
            s_meta <= slow_clk;
            s_last <= s_meta;
        end
    end
`else
    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            s_last <= 1'b0;
        end else begin
            s_last <= slow_clk;
        end
    end
`endif

    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= s_last;
        end
    end

    assign slow_rise = s_last & ~s_prev;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en)  state_next = RUN;
            RUN:     if (!en) state_next = HOLD;
            HOLD:    if (en)  state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Count only when already running and still enabled, so the RUN->HOLD edge is ignored.
    assign step     = slow_rise && (state == RUN) && en;
    assign at_limit = up_dn ? (count >= MAX_V) : (count == '0);

    always_comb begin
        count_step = count;
        if (up_dn) begin
            count_step = at_limit ? '0 : count + 1'b1;
        end else begin
            count_step = at_limit ? MAX_V : count - 1'b1;
        end
    end

    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            tick_o <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            state  <= state_next;
            tick_o <= slow_rise;
            wrap_o <= 1'b0;
            if (load) begin
                count <= load_clamped;
            end else if (step) begin
                count  <= count_step;
                wrap_o <= at_limit;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_led_counter.sv
// Directed self-checking bench for led_counter; a second instance with MAX=9 checks load clamping.
module tb_led_counter;

`ifdef LED_COUNTER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       in_clk = 1'b0;
    logic       rst_n, slow_clk, en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] count, count9;
    logic       tick_o, wrap_o, tick9, wrap9;
    logic [1:0] state_o, state9;

    int compared = 0;
    int failed   = 0;
    int tick_cnt = 0;
    int wrap_cnt = 0;
    logic last_wrap;

    always #5 in_clk = ~in_clk;

    led_counter #(.WIDTH(4), .MAX(15)) dut (
        .in_clk(in_clk), .rst_n(rst_n), .slow_clk(slow_clk), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .count(count), .tick_o(tick_o),
        .wrap_o(wrap_o), .state_o(state_o)
    );

    led_counter #(.WIDTH(4), .MAX(9)) dut9 (
        .in_clk(in_clk), .rst_n(rst_n), .slow_clk(slow_clk), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .count(count9), .tick_o(tick9),
        .wrap_o(wrap9), .state_o(state9)
    );

    always @(negedge in_clk) begin
        if (tick_o === 1'b1) tick_cnt++;
        if (wrap_o === 1'b1) wrap_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge in_clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One slow_clk pulse: high 4 cycles, low 4 cycles; remembers wrap_o seen alongside the tick.
    task automatic apply_stimulus_pulse();
        last_wrap = 1'b0;
        slow_clk  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) slow_clk = 1'b0;
            cyc(1);
            if (tick_o === 1'b1) last_wrap = wrap_o;
        end
    endtask

    task automatic apply_stimulus_load(input logic [3:0] val);
        load     = 1'b1;
        load_val = val;
        cyc(1);
        load     = 1'b0;
    endtask

    initial begin
        int tick_base;
        int wrap_base;
        int first_k;
        logic [3:0] prev_count;

        rst_n = 1'b0; slow_clk = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        cyc(2);
        check_output("reset_count", count, 0);
        check_output("reset_state", state_o, 0);
        check_output("reset_tick", tick_o, 0);
        check_output("reset_wrap", wrap_o, 0);

        rst_n = 1'b1; en = 1'b1;
        cyc(1);
        check_output("first_edge_run", state_o, 1);

        // 16 up pulses: 1..15 then 0 with a single wrap
        tick_base = tick_cnt; wrap_base = wrap_cnt;
        for (int i = 1; i <= 16; i++) begin
            apply_stimulus_pulse();
            check_output($sformatf("up_count_%0d", i), count, i % 16);
        end
        check_output("up_wrap_at_15_to_0", last_wrap, 1);
        check_output("up_wrap_total", wrap_cnt - wrap_base, 1);
        check_output("up_tick_total", tick_cnt - tick_base, 16);

        // load 3 then count down 2,1,0,15
        apply_stimulus_load(4'd3);
        check_output("load3_count", count, 3);
        check_output("load3_wrap", wrap_o, 0);
        up_dn = 1'b0;
        wrap_base = wrap_cnt;
        apply_stimulus_pulse(); check_output("dn_count_2", count, 2);
        apply_stimulus_pulse(); check_output("dn_count_1", count, 1);
        apply_stimulus_pulse(); check_output("dn_count_0", count, 0);
        apply_stimulus_pulse(); check_output("dn_count_15", count, 15);
        check_output("dn_wrap_at_0_to_15", last_wrap, 1);
        check_output("dn_wrap_total", wrap_cnt - wrap_base, 1);

        // hold: count frozen at 5 while ticks continue
        up_dn = 1'b1;
        apply_stimulus_load(4'd5);
        check_output("load5_count", count, 5);
        en = 1'b0;
        cyc(1);
        check_output("hold_state", state_o, 2);
        tick_base = tick_cnt;
        repeat (3) apply_stimulus_pulse();
        check_output("hold_count", count, 5);
        check_output("hold_ticks", tick_cnt - tick_base, 3);
        en = 1'b1;
        cyc(1);
        check_output("resume_state", state_o, 1);
        apply_stimulus_pulse();
        check_output("resume_count", count, 6);

        // load coincident with a detected edge wins, no wrap
        apply_stimulus_load(4'd2);
        check_output("load2_count", count, 2);
        slow_clk = 1'b1;
        cyc(LAT - 1);
        load = 1'b1; load_val = 4'd7;
        cyc(1);
        load = 1'b0;
        check_output("coincide_tick", tick_o, 1);
        check_output("coincide_count", count, 7);
        check_output("coincide_wrap", wrap_o, 0);
        cyc(4);
        slow_clk = 1'b0;
        cyc(4);
        check_output("coincide_after", count, 7);
        apply_stimulus_load(4'd12);
        check_output("load12_max15", count, 12);
        check_output("load12_max9_clamp", count9, 9);

        // reset mid-operation with slow_clk high
        apply_stimulus_load(4'd11);
        check_output("load11_count", count, 11);
        slow_clk = 1'b1; rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1; en = 1'b0;
        check_output("midrst_count", count, 0);
        check_output("midrst_state", state_o, 0);
        check_output("midrst_wrap", wrap_o, 0);
        tick_base = tick_cnt;
        cyc(10);
        check_output("high_level_one_tick", tick_cnt - tick_base, 1);
        check_output("idle_tick_count", count, 0);
        check_output("idle_state", state_o, 0);

        // latency from slow_clk rise to first count change
        slow_clk = 1'b0;
        cyc(4);
        en = 1'b1; up_dn = 1'b1;
        cyc(1);
        check_output("lat_state", state_o, 1);
        prev_count = count;
        first_k = 0;
        slow_clk = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            if (first_k == 0 && count !== prev_count) first_k = k;
        end
        slow_clk = 1'b0;
        check_output("rise_latency", first_k, LAT);
        check_output("lat_count", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/led_counter.md
LED_COUNTER -- requirements
Module: led_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, count/LED width in bits.
REQ-002 SHALL have parameter MAX, default 15, terminal count (modulus MAX+1); legal range 1..2^WIDTH-1.
REQ-003 SHALL have port in_clk  input  1  sole system clock (125 MHz board clock); all flops on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port slow_clk  input  1  divided 1 Hz clock from the upstream clock divider; sampled as data, never used as a clock.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up_dn  input  1  direction; 1 = up, 0 = down.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  load value.
REQ-010 SHALL have port count  output  WIDTH  registered count, drives LEDs.
REQ-011 SHALL have port tick_o  output  1  registered one-cycle pulse, one per detected slow_clk rising edge.
REQ-012 SHALL have port wrap_o  output  1  registered one-cycle pulse on count wrap.
REQ-013 SHALL have port state_o  output  2  FSM state: IDLE=00, RUN=01, HOLD=10; 11 never driven.

Function
REQ-014 SHALL detect slow_clk rising edges: edge = s_last & ~s_prev, where s_last is the last synchronizer stage and s_prev is that stage delayed one in_clk.
REQ-015 SHALL assert tick_o for exactly one in_clk cycle per slow_clk rising edge, independent of FSM state; never for a falling edge or a steady level.
REQ-016 SHALL implement FSM transitions: IDLE->RUN when en=1; RUN->HOLD when en=0; HOLD->RUN when en=1; IDLE stays IDLE while en=0.
REQ-017 SHALL change count on an edge only when state is RUN and en=1 in that same cycle; an edge in IDLE or HOLD, or coinciding with RUN->HOLD, leaves count unchanged.
REQ-018 SHALL, when counting up, step count+1; at count=MAX step to 0 and pulse wrap_o.
REQ-019 SHALL, when counting down, step count-1; at count=0 step to MAX and pulse wrap_o.
REQ-020 SHALL update count and tick_o on the same in_clk edge (count and tick_o are coincident).
REQ-021 SHALL, when load=1, write min(load_val, MAX) to count on the next in_clk edge, in any state, with priority over a coincident edge; wrap_o stays 0 and state is unchanged.
REQ-022 SHALL sample up_dn per edge, so a direction change takes effect on the next counted edge.
REQ-023 SHALL never hold count > MAX.

Reset
REQ-024 SHALL, on any in_clk edge with rst_n=0, clear count=0, tick_o=0, wrap_o=0, state=IDLE, and all synchronizer/edge registers to 0.
REQ-025 SHALL abort mid-operation on reset; a slow_clk already high at reset release SHALL produce a tick (registers clear to 0), but count SHALL stay unchanged because state is IDLE.
REQ-026 SHALL allow en sampled on the first edge after reset release to move IDLE->RUN on that edge.

Configuration
REQ-027 SHALL support macro LED_COUNTER_SYNC_EN; when defined, slow_clk passes through a 2-flop synchronizer before edge detection, and count/tick_o update on the 3rd in_clk edge that samples slow_clk=1.
REQ-028 SHALL, with LED_COUNTER_SYNC_EN undefined, use a single register stage, and count/tick_o update on the 2nd in_clk edge that samples slow_clk=1; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset, en=1, up_dn=1, 16 slow_clk pulses -> count 1..15 then 0; wrap_o high exactly once, coincident with 15->0; 16 tick_o pulses.
REQ-030 SHALL cover: load=1, load_val=3, then up_dn=0 and 4 pulses -> count 2,1,0,15; wrap_o on 0->15.
REQ-031 SHALL cover: count=5 in RUN, en=0, 3 pulses -> state HOLD, count stays 5, 3 tick_o pulses; en=1, 1 pulse -> count 6.
REQ-032 SHALL cover: load=1, load_val=7 on the same cycle as an edge, count=2 -> count=7 and wrap_o=0; MAX=9 with load_val=12 -> count=9.
REQ-033 SHALL cover: rst_n=0 for 1 cycle while count=11 and slow_clk high -> next cycle count=0, state=IDLE, wrap_o=0.
REQ-034 SHALL cover: slow_clk rises, with and without LED_COUNTER_SYNC_EN -> first count change exactly 3 and 2 sampling edges after the rise, respectively; slow_clk held high 10 cycles -> exactly one tick_o.
